// File: rtl/lcd_spi_write.sv
// Byte-level SPI (mode 0) transmitter for the ST7735 LCD init/control stream.
// Samples a 9-bit {dc, byte} word, shifts it MSB-first, then pulses wr_done.
module lcd_spi_write #(
   parameter int HALF_DIV = 2,
   parameter int GAP_CYC  = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       en_write,
   input  logic [8:0] init_data,
   output logic       wr_done,
   output logic       busy,
   output logic       lcd_cs,
   output logic       lcd_dc,
   output logic       lcd_sclk,
   output logic       lcd_mosi
);

   localparam int CW = $clog2(HALF_DIV + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] half_cnt, half_cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          wr_done_n, busy_n, cs_n, dc_n, sclk_n, mosi_n;
   logic          half_last;

   assign half_last = (half_cnt == HALF_LAST);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         half_cnt <= '0;
         gap_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         wr_done  <= 1'b0;
         busy     <= 1'b0;
         lcd_cs   <= 1'b1;
         lcd_dc   <= 1'b0;
         lcd_sclk <= 1'b0;
         lcd_mosi <= 1'b0;
      end else begin
         state    <= state_n;
         half_cnt <= half_cnt_n;
         gap_cnt  <= gap_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         wr_done  <= wr_done_n;
         busy     <= busy_n;
         lcd_cs   <= cs_n;
         lcd_dc   <= dc_n;
         lcd_sclk <= sclk_n;
         lcd_mosi <= mosi_n;
      end
   end

   // Next-state logic also computes next output values so every pin is registered.
   always_comb begin
      state_n    = state;
      half_cnt_n = half_cnt;
      gap_cnt_n  = gap_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      wr_done_n  = 1'b0;
      busy_n     = busy;
      cs_n       = lcd_cs;
      dc_n       = lcd_dc;
      sclk_n     = lcd_sclk;
      mosi_n     = lcd_mosi;

      unique case (state)
         IDLE: begin
            if (en_write) begin
               state_n    = SETUP;
               half_cnt_n = '0;
               bit_cnt_n  = 3'd7;
               shreg_n    = init_data[7:0];
               dc_n       = init_data[8];
               mosi_n     = init_data[7];
               cs_n       = 1'b0;
               sclk_n     = 1'b0;
               busy_n     = 1'b1;
            end
         end
         SETUP: begin
            if (half_last) begin
               state_n    = SHIFT;
               half_cnt_n = '0;
            end else begin
               half_cnt_n = half_cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (!half_last) begin
               half_cnt_n = half_cnt + 1'b1;
            end else begin
               half_cnt_n = '0;
               if (!lcd_sclk) begin
                  sclk_n = 1'b1;
               end else if (bit_cnt == 3'd0) begin
                  state_n = HOLD;
                  sclk_n  = 1'b0;
               end else begin
                  // Falling edge of SCLK presents the next bit in the same cycle.
                  sclk_n    = 1'b0;
                  bit_cnt_n = bit_cnt - 3'd1;
                  mosi_n    = shreg[bit_cnt - 3'd1];
               end
            end
         end
         HOLD: begin
            if (half_last) begin
               state_n    = DONE;
               half_cnt_n = '0;
               cs_n       = 1'b1;
               wr_done_n  = 1'b1;
            end else begin
               half_cnt_n = half_cnt + 1'b1;
            end
         end
         DONE: begin
            state_n   = GAP;
            gap_cnt_n = '0;
         end
         GAP: begin
            // Lets the source bump its pointer and re-register init_data.
            if (gap_cnt == GAP_LAST) begin
               state_n   = IDLE;
               gap_cnt_n = '0;
               busy_n    = 1'b0;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
